alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing ALUControl encodings and their one-cycle ops: AND, OR, ADD, SUB, PASS_B.
- Adds iterative unsigned multiply, divide and remainder, behind a start/busy/done handshake with a registered result.
- Sits in the execute stage of the multi-cycle core; the control FSM stalls while busy=1.

Parameters:
- N, 64, data width in bits (N >= 4; power of two).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  N  operand A.
- b  in  N  operand B.
- ALUControl  in  4  operation select, sampled with start.
- result  out  N  registered result; held between operations.
- zero  out  1  registered; 1 iff result == 0.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse when result/zero update.

Behaviour:
- Reset values (asynchronous, immediate): result=0, zero=1, busy=0, done=0, FSM=IDLE, counter=0, working regs=0.
- Reset mid-operation aborts the operation; no done pulse.
- FSM states: IDLE, CALC.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS_B: single-cycle.
  - 1000 MUL: low N bits of unsigned a*b.
  - 1001 UDIV: unsigned a/b.
  - 1010 UREM: unsigned a%b.
  - Any other code: single-cycle, result=0.
- ADD/SUB/MUL: modulo 2^N; carries discarded.
- Start accepted at rising edge k with FSM=IDLE and start=1. a, b, ALUControl are latched at edge k.
- Single-cycle ops:
  - result/zero written at edge k; done=1 for the cycle after edge k.
  - FSM stays IDLE; busy stays 0.
- MUL, UDIV, UREM:
  - Edge k: latch operands, FSM->CALC, busy=1, count=0.
  - Edges k+1..k+N: one iteration each.
  - Edge k+N: final value written to result/zero; done=1 for one cycle; busy=0; FSM->IDLE.
  - busy is high for exactly N cycles.
- MUL (shift-add):
  - Per iteration: if multiplier LSB=1, acc += multiplicand.
  - Then multiplicand <<= 1 and multiplier >>= 1; acc is N bits.
- UDIV/UREM (restoring):
  - Per iteration: rem = {rem, dividend MSB}; dividend <<= 1.
  - If rem >= divisor (N+1-bit compare): rem -= divisor and quotient bit = 1.
  - UDIV returns the quotient; UREM returns rem.
- Divide by zero (b==0 at start):
  - Completes as a single-cycle op: done after edge k, no CALC.
  - UDIV result = all ones; UREM result = a.
- While busy=1: start ignored; a/b/ALUControl changes have no effect.
- result and zero hold their previous values throughout CALC.
- start=1 during the done cycle is legal: FSM is IDLE, so it is accepted (back-to-back ops).
- done never asserts without a prior accepted start.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, add three outputs, registered alongside result and reset to 0:
  - negative (1) = result[N-1].
  - carry (1): ADD = carry out of bit N-1; SUB = NOT borrow, i.e. a >= b unsigned.
  - overflow (1) = signed overflow of ADD/SUB.
  - carry and overflow are 0 for all other ops.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- ADD, a=55, b=23 -> done one cycle after the start edge; result=78, zero=0, busy never 1. Then SUB with a=59, b=-36 -> result=95.
- AND with a=-68, b=-63 -> result=0xFFFF_FFFF_FFFF_FF80. Then PASS_B with b=0 -> result=0, zero=1. Then opcode 1111 -> result=0, zero=1.
- MUL, a=-68, b=-63 (N=64) -> busy high 64 cycles; done at edge k+64; result=0xFFFF_FFFF_FFFF_FFFF*0 check: low 64 bits = (2^64-68)*(2^64-63) mod 2^64 = 4284. Also: result holds its prior value during CALC; start pulses during busy are ignored.
- UDIV, a=100, b=7 -> 14 after 64 cycles. UREM, a=100, b=7 -> 2. UREM, a=21, b=7 -> 0 with zero=1. Issue back-to-back by asserting start in the done cycle.
- Divide by zero, a=5, b=0 -> UDIV gives 0xFFFF_FFFF_FFFF_FFFF one cycle after start; UREM gives 5; busy stays 0.
- reset asserted 10 cycles into a MUL -> outputs go to reset values immediately and no done pulse appears. Next ADD 1+1 after reset -> 2. With ALU_FLAGS_EN: ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> overflow=1, negative=1, carry=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with single-cycle logic/arith ops and iterative MUL/UDIV/UREM.
// Define ALU_FLAGS_EN to add the registered negative/carry/overflow outputs.
module alu_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         busy,
  output logic         done
`ifdef ALU_FLAGS_EN
  ,
  output logic         negative,
  output logic         carry,
  output logic         overflow
`endif
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [N-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, result_q, result_d;
  logic zero_q, zero_d, done_q, done_d;
  logic [N-1:0] add, sub, alu_r, x_n, y_n, acc_n, t2;
  logic [N:0] t;
  logic ge, multi, div0;
`ifdef ALU_FLAGS_EN
  logic n_q, n_d, c_q, c_d, v_q, v_d, alu_c, alu_v;
`endif
  always_comb begin
    add = a + b;
    sub = a - b;
    multi = ALUControl == 4'b1000 || ALUControl == 4'b1001 || ALUControl == 4'b1010;
    div0 = (ALUControl == 4'b1001 || ALUControl == 4'b1010) && b == '0;
    case (ALUControl)
      4'b0000: alu_r = a & b;
      4'b0001: alu_r = a | b;
      4'b0010: alu_r = add;
      4'b0110: alu_r = sub;
      4'b0111: alu_r = b;
      4'b1001: alu_r = '1;
      4'b1010: alu_r = a;
      default: alu_r = '0;
    endcase
`ifdef ALU_FLAGS_EN
    alu_c = ALUControl == 4'b0010 ? add < a : ALUControl == 4'b0110 ? a >= b : 1'b0;
    alu_v = ALUControl == 4'b0010 ? a[N-1] == b[N-1] && add[N-1] != a[N-1] :
            ALUControl == 4'b0110 ? a[N-1] != b[N-1] && sub[N-1] != a[N-1] : 1'b0;
`endif
    // restoring-divide step; the quotient bit shifts into the dividend's LSB
    t = {acc_q, x_q[N-1]};
    ge = t >= {1'b0, y_q};
    t2 = ge ? N'(t - {1'b0, y_q}) : t[N-1:0];
    acc_n = op_q == 2'b00 ? acc_q + (y_q[0] ? x_q : '0) : t2;
    x_n = {x_q[N-2:0], op_q != 2'b00 && ge};
    y_n = op_q == 2'b00 ? y_q >> 1 : y_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    x_d = x_q;
    y_d = y_q;
    acc_d = acc_q;
    result_d = result_q;
    done_d = 1'b0;
`ifdef ALU_FLAGS_EN
    c_d = c_q;
    v_d = v_q;
`endif
    if (state_q == IDLE && start) begin
      if (multi && !div0) begin
        state_d = CALC;
        cnt_d = '0;
        op_d = ALUControl[1:0];
        x_d = a;
        y_d = b;
        acc_d = '0;
      end else begin
        result_d = alu_r;
        done_d = 1'b1;
`ifdef ALU_FLAGS_EN
        c_d = alu_c;
        v_d = alu_v;
`endif
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      x_d = x_n;
      y_d = y_n;
      acc_d = acc_n;
      if (cnt_q == CW'(N - 1)) begin
        state_d = IDLE;
        result_d = op_q == 2'b01 ? x_n : acc_n;
        done_d = 1'b1;
`ifdef ALU_FLAGS_EN
        c_d = 1'b0;
        v_d = 1'b0;
`endif
      end
    end
    zero_d = result_d == '0;
`ifdef ALU_FLAGS_EN
    n_d = result_d[N-1];
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
      result_q <= result_d;
      zero_q <= zero_d;
      done_q <= done_d;
`ifdef ALU_FLAGS_EN
      n_q <= n_d;
      c_q <= c_d;
      v_q <= v_d;
`endif
    end
  end
  always_comb begin
    result = result_q;
    zero = zero_q;
    busy = state_q == CALC;
    done = done_q;
`ifdef ALU_FLAGS_EN
    negative = n_q;
    carry = c_q;
    overflow = v_q;
`endif
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N=64).
module tb_alu_seq;
  localparam int N = 64;
  logic clk = 1'b0;
  logic reset, start, zero, busy, done;
  logic [N-1:0] a, b, result;
  logic [3:0] ctl;
`ifdef ALU_FLAGS_EN
  logic negative, carry, overflow;
`endif
  int total = 0;
  int bad = 0;
  int cyc, bcnt, herr, dcnt;
  alu_seq #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ctl),
    .result(result), .zero(zero), .busy(busy), .done(done)
`ifdef ALU_FLAGS_EN
    , .negative(negative), .carry(carry), .overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // issue one op from a sample point; returns at the sample point of the done cycle
  task automatic op(input logic [3:0] c, input logic [N-1:0] x, input logic [N-1:0] y,
                    input bit poke, output int cy, output int bc, output int he);
    logic [N-1:0] prior;
    prior = result;
    ctl = c; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cy = 0; bc = int'(busy); he = 0;
    while (!done && cy < 200) begin
      if (busy && result !== prior) he++;
      if (poke && cy == 5) begin
        start = 1'b1; ctl = 4'b0010; a = 64'd1; b = 64'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cy++;
      bc += int'(busy);
    end
  endtask
  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0; ctl = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    op(4'b0010, 64'd55, 64'd23, 0, cyc, bcnt, herr);
    check("add_res", result, 64'd78);
    check("add_zero", zero, 0);
    check("add_lat", cyc, 0);
    check("add_busy", bcnt, 0);
    op(4'b0110, 64'd59, -64'sd36, 0, cyc, bcnt, herr);
    check("sub_res", result, 64'd95);
    op(4'b1000, -64'sd68, -64'sd63, 1, cyc, bcnt, herr);
    check("mul_res", result, 64'd4284);
    check("mul_lat", cyc, 64);
    check("mul_busy", bcnt, 64);
    check("mul_hold", herr, 0);
    @(posedge clk); #1;
    check("mul_done_pulse", done, 0);
    check("mul_poke_ignored", result, 64'd4284);
    op(4'b0000, -64'sd68, -64'sd63, 0, cyc, bcnt, herr);
    check("and_res", result, 64'hFFFF_FFFF_FFFF_FF80);
    op(4'b0111, 64'd9, 64'd0, 0, cyc, bcnt, herr);
    check("passb_res", result, 0);
    check("passb_zero", zero, 1);
    op(4'b0001, 64'd5, 64'd3, 0, cyc, bcnt, herr);
    check("or_res", result, 64'd7);
    op(4'b1111, 64'd5, 64'd3, 0, cyc, bcnt, herr);
    check("bad_op_res", result, 0);
    check("bad_op_zero", zero, 1);
    op(4'b1001, 64'd100, 64'd7, 0, cyc, bcnt, herr);
    check("udiv_res", result, 64'd14);
    check("udiv_lat", cyc, 64);
    op(4'b1010, 64'd100, 64'd7, 0, cyc, bcnt, herr);
    check("urem_res", result, 64'd2);
    check("urem_lat", cyc, 64);
    op(4'b1010, 64'd21, 64'd7, 0, cyc, bcnt, herr);
    check("urem0_res", result, 0);
    check("urem0_zero", zero, 1);
    op(4'b1001, 64'd5, 64'd0, 0, cyc, bcnt, herr);
    check("div0_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_lat", cyc, 0);
    check("div0_busy", bcnt, 0);
    op(4'b1010, 64'd5, 64'd0, 0, cyc, bcnt, herr);
    check("rem0_res", result, 64'd5);
    check("rem0_busy", bcnt, 0);
    ctl = 4'b1000; a = 64'd3; b = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      dcnt += int'(done) + int'(busy);
    end
    check("abort_no_done", dcnt, 0);
    op(4'b0010, 64'd1, 64'd1, 0, cyc, bcnt, herr);
    check("post_rst_add", result, 64'd2);
`ifdef ALU_FLAGS_EN
    op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, cyc, bcnt, herr);
    check("flg_res", result, 64'h8000_0000_0000_0000);
    check("flg_ovf", overflow, 1);
    check("flg_neg", negative, 1);
    check("flg_carry", carry, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
